// File: rtl/enc_pkg.sv
// Shared types and constants for the req_enc16 request encoder.
//   NREQ        number of request lines (16)
//   CW          code width, $clog2(NREQ)
//   enc_state_t handshake stage state: IDLE (nothing presented), PRESENT (valid code)
//   onehot()    expands a code into the request bit it refers to
package enc_pkg;

  localparam int unsigned NREQ = 16;
  localparam int unsigned CW   = 4;

  typedef enum logic {IDLE, PRESENT} enc_state_t;

  typedef logic [NREQ-1:0] req_vec_t;
  typedef logic [CW-1:0]   code_t;

  function automatic req_vec_t onehot(code_t c);
    onehot = req_vec_t'(1) << c;
  endfunction

endpackage

// File: rtl/req_enc16_if.sv
// Code handshake between req_enc16 and its consumer.
//   code   encoded request index (producer -> consumer)
//   valid  code is meaningful       (producer -> consumer)
//   ready  consumer takes the code  (consumer -> producer)
// A transfer happens on a rising edge where valid && ready.
interface req_enc16_if;
  import enc_pkg::*;

  code_t code;
  logic  valid;
  logic  ready;

  modport master (output code, output valid, input  ready);
  modport slave  (input  code, input  valid, output ready);

endinterface

// File: rtl/prio_enc16.sv
// Combinational 16-input priority encoder with a movable starting point.
//   vec   request vector to search
//   base  first index examined; the search runs upward and wraps 15 -> 0
//   idx   first set index found from base (0 when nothing is set)
//   any   at least one bit of vec is set
module prio_enc16
  import enc_pkg::*;
(
  input  req_vec_t vec,
  input  code_t    base,
  output code_t    idx,
  output logic     any
);

  code_t probe;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    probe = '0;
    any   = |vec;
    for (int i = NREQ - 1; i >= 0; i--) begin
      probe = base + code_t'(i);
      if (vec[probe]) begin
        idx = probe;
      end
    end
  end

endmodule

// File: rtl/req_enc16.sv
// Sequential 16-to-4 request encoder.
// Request pulses are captured into a sticky pending register; one pending index at a time
// is presented as a code on a valid/ready handshake and is cleared only when accepted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   req    request lines, sampled every edge (one-cycle pulse is enough)
//   flush  synchronous clear of pending register and output stage
//   pend   pending register, for status readback
//   bus    code/valid/ready handshake (master side)
// Build option:
//   REQ_ENC16_RR_EN  round-robin arbitration starting after the last accepted code;
//                    when undefined the lowest pending index always wins.
module req_enc16
  import enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  req_vec_t    req,
  input  logic        flush,
  output req_vec_t    pend,
  req_enc16_if.master bus
);

  enc_state_t state_q, state_d;
  req_vec_t   pend_q, pend_d;
  code_t      code_q, code_d;

  logic       valid;
  logic       acc;
  req_vec_t   clr;
  req_vec_t   pend_nx;
  code_t      base;
  code_t      idx;
  logic       any;

  assign valid = (state_q == PRESENT);
  assign acc   = valid & bus.ready;
  assign clr   = acc ? onehot(code_q) : '0;
  // A request arriving in the accept cycle of the same index survives the clear.
  assign pend_nx = (pend_q & ~clr) | req;

`ifdef REQ_ENC16_RR_EN
  code_t last_q, last_d;

  // On an accept the pointer is about to become code_q, so search from there already.
  assign base = (acc ? code_q : last_q) + code_t'(1);
`else
  assign base = '0;
`endif

  prio_enc16 u_prio (
    .vec  (pend_nx),
    .base (base),
    .idx  (idx),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pend_d  = pend_nx;
`ifdef REQ_ENC16_RR_EN
    last_d  = last_q;
`endif
    if (flush) begin
      state_d = IDLE;
      code_d  = '0;
      pend_d  = '0;
`ifdef REQ_ENC16_RR_EN
      last_d  = '1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            code_d  = idx;
            state_d = PRESENT;
          end
        end
        PRESENT: begin
          // Without an accept the code must hold still; only pend may grow.
          if (acc) begin
`ifdef REQ_ENC16_RR_EN
            last_d = code_q;
`endif
            if (any) begin
              code_d = idx;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
    end
  end

`ifdef REQ_ENC16_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign pend      = pend_q;
  assign bus.code  = code_q;
  assign bus.valid = valid;

endmodule

// File: tb/tb_req_enc16.sv
module tb_req_enc16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        flush;
  logic [15:0] pend;

  req_enc16_if bus ();

  req_enc16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .flush (flush),
    .pend  (pend),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    int unsigned n;
    logic [63:0] codes;  // expected codes, lowest-index order, nibble 0 first
  } vec_t;

  vec_t        tbl [6];
  logic [3:0]  exp_q [$];
  logic [3:0]  tb_last;
  int unsigned n_cmp;
  int unsigned n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue the expected service order for a set of codes listed in ascending order.
  task automatic push_list(input logic [63:0] codes, input int unsigned n);
    int unsigned start;
    logic [3:0]  c;
    start = 0;
`ifdef REQ_ENC16_RR_EN
    for (int j = int'(n) - 1; j >= 0; j--) begin
      c = codes[4*j +: 4];
      if (c > tb_last) start = j;
    end
`endif
    for (int unsigned k = 0; k < n; k++) begin
      c = codes[4*((start + k) % n) +: 4];
      exp_q.push_back(c);
      tb_last = c;
    end
  endtask

  // One clock: score any handshake completing at the coming edge, then step past it.
  task automatic tick();
    @(negedge clk);
    if (bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected accept: got code %0h, expected no transfer", bus.code);
      end else begin
        chk("accepted code", 64'(bus.code), 64'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int unsigned t;
    t = 0;
    while ((exp_q.size() != 0 || bus.valid) && t < 60) begin
      tick();
      t++;
    end
    chk({name, " drained"}, 64'(exp_q.size() == 0 && !bus.valid), 64'd1);
    chk({name, " pend empty"}, 64'(pend), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    tb_last   = 4'hF;
    rst_n     = 1'b0;
    req       = '0;
    flush     = 1'b0;
    bus.ready = 1'b0;

    tbl[0] = '{vec: 16'h0200, n: 1,  codes: 64'h9};
    tbl[1] = '{vec: 16'h8421, n: 4,  codes: 64'hFA50};
    tbl[2] = '{vec: 16'h0001, n: 1,  codes: 64'h0};
    tbl[3] = '{vec: 16'h8000, n: 1,  codes: 64'hF};
    tbl[4] = '{vec: 16'h0C00, n: 2,  codes: 64'hBA};
    tbl[5] = '{vec: 16'hFFFF, n: 16, codes: 64'hFEDC_BA98_7654_3210};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset valid", 64'(bus.valid), 64'd0);
    chk("reset code", 64'(bus.code), 64'd0);
    chk("reset pend", 64'(pend), 64'd0);

    // One-cycle request bursts with the consumer always ready.
    bus.ready = 1'b1;
    for (int e = 0; e < 6; e++) begin
      push_list(tbl[e].codes, tbl[e].n);
      req = tbl[e].vec;
      tick();
      req = '0;
      chk($sformatf("vec%0d latency valid", e), 64'(bus.valid), 64'd1);
      chk($sformatf("vec%0d first code", e), 64'(bus.code), 64'(exp_q[0]));
      drain($sformatf("vec%0d", e));
    end

    // Backpressure: code held stable while pend keeps both requests.
    bus.ready = 1'b0;
    push_list(64'h43, 2);
    req = 16'h0018;
    tick();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      chk("hold valid", 64'(bus.valid), 64'd1);
      chk("hold code", 64'(bus.code), 64'd3);
      chk("hold pend", 64'(pend), 64'h0018);
      tick();
    end
    bus.ready = 1'b1;
    drain("backpressure");

    // Set dominates clear, then flush beats a new request.
    bus.ready = 1'b0;
    req = 16'h0004;
    tick();
    req = '0;
    chk("sdc first code", 64'(bus.code), 64'd2);
    push_list(64'h2, 1);
    bus.ready = 1'b1;
    req = 16'h0004;
    tick();
    req = '0;
    bus.ready = 1'b0;
    chk("sdc valid again", 64'(bus.valid), 64'd1);
    chk("sdc code again", 64'(bus.code), 64'd2);
    chk("sdc pend kept", 64'(pend), 64'h0004);
    flush = 1'b1;
    req = 16'h0001;
    tick();
    flush = 1'b0;
    req = '0;
    tb_last = 4'hF;
    chk("flush valid", 64'(bus.valid), 64'd0);
    chk("flush code", 64'(bus.code), 64'd0);
    chk("flush pend", 64'(pend), 64'd0);
    tick();
    chk("post-flush idle", 64'(bus.valid), 64'd0);
    chk("scoreboard after flush", 64'(exp_q.size()), 64'd0);

    // Priority order with a re-request of the index just accepted.
    req = 16'h000A;
    tick();
    req = '0;
    chk("prio first code", 64'(bus.code), 64'd1);
`ifdef REQ_ENC16_RR_EN
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd1);
`else
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
`endif
    tb_last = exp_q[2];
    bus.ready = 1'b1;
    req = 16'h0002;
    tick();
    req = '0;
    drain("priority");

    // Asynchronous reset in the middle of a presented code.
    bus.ready = 1'b0;
    req = 16'h0020;
    tick();
    req = 16'h0040;
    chk("pre-reset code", 64'(bus.code), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 64'(bus.valid), 64'd0);
    chk("async reset code", 64'(bus.code), 64'd0);
    chk("async reset pend", 64'(pend), 64'd0);
    req = '0;
    tb_last = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle after reset", 64'({bus.valid, pend}), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
